// File: rtl/program_run_sequencer.sv
// Fetches instruction words pc 0..DEPTH-1 and issues each one, followed by an idle separator, over valid/ready.
// Latency: start to first instr_valid is 3 edges; per word 2 handshakes + PACE_CYCLES + 2 fetch cycles.
// Backpressure: instr/instr_valid hold until instr_ready; stop aborts to IDLE from any busy state.
module program_run_sequencer #(
    parameter int          ADDR_W      = 3,
    parameter int          DEPTH       = 8,
    parameter int          PACE_CYCLES = 100000000,
    parameter int          LOOP        = 0,
    parameter logic [11:0] SEP_INSTR   = 12'hE00,
    parameter logic [11:0] HALT_INSTR  = 12'hFFF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] IM_add,
    input  logic [11:0]       IM_rd,
    output logic [11:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc
);

    localparam int                CNT_W    = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PACE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPT, S_ISSUE, S_SEP, S_PACE, S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             xfer;

    assign xfer   = instr_valid && instr_ready;
    assign IM_add = pc;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr       <= SEP_INSTR;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
        end else if (stop && busy) begin
            // Abort keeps pc for observation; the next start rewinds it.
            state       <= S_IDLE;
            instr       <= SEP_INSTR;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_CAPT;
                S_CAPT: begin
                    if (IM_rd == HALT_INSTR) begin
                        instr       <= SEP_INSTR;
                        instr_valid <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        instr       <= IM_rd;
                        instr_valid <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        instr <= SEP_INSTR;
                        state <= S_SEP;
                    end
                end
                S_SEP: begin
                    if (xfer) begin
                        instr_valid <= 1'b0;
                        cnt         <= CNT_LOAD;
                        state       <= S_PACE;
                    end
                end
                S_PACE: begin
                    if (cnt == '0) begin
                        if (pc == LAST_PC && LOOP == 0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            pc    <= (pc == LAST_PC) ? '0 : pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (start && !stop) begin
                        pc    <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_run_sequencer.sv
// Directed bench: a one-shot sequencer and a looping one share a synchronous-read instruction memory.
module tb_program_run_sequencer;

    logic        CLK = 1'b0;
    logic        reset, start, stop, instr_ready;
    logic        start_l, stop_l;
    logic [2:0]  IM_add, pc, IM_add_l, pc_l;
    logic [11:0] IM_rd, instr, IM_rd_l, instr_l;
    logic        instr_valid, busy, done, instr_valid_l, busy_l, done_l;

    logic [11:0] mem [8];
    logic [11:0] xfer_q [$];
    logic [11:0] xfer_l_q [$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        loop_run = 1'b0;
    int          busy_low_cnt = 0;

    always #5 CLK = ~CLK;

    program_run_sequencer #(.ADDR_W(3), .DEPTH(8), .PACE_CYCLES(4), .LOOP(0)) dut (
        .CLK(CLK), .reset(reset), .start(start), .stop(stop),
        .IM_add(IM_add), .IM_rd(IM_rd), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy), .done(done), .pc(pc)
    );

    program_run_sequencer #(.ADDR_W(3), .DEPTH(8), .PACE_CYCLES(4), .LOOP(1)) dut_loop (
        .CLK(CLK), .reset(reset), .start(start_l), .stop(stop_l),
        .IM_add(IM_add_l), .IM_rd(IM_rd_l), .instr(instr_l), .instr_valid(instr_valid_l),
        .instr_ready(instr_ready), .busy(busy_l), .done(done_l), .pc(pc_l)
    );

    always @(posedge CLK) begin
        IM_rd   <= mem[IM_add];
        IM_rd_l <= mem[IM_add_l];
    end

    // Inputs only change just after a rising edge, so the negedge view is what the next edge sees.
    always @(negedge CLK) begin
        if (!reset && instr_valid && instr_ready)     xfer_q.push_back(instr);
        if (!reset && instr_valid_l && instr_ready)   xfer_l_q.push_back(instr_l);
        if (loop_run && !busy_l)                      busy_low_cnt++;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !done; i++) tick();
        check_vec(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !instr_valid; i++) tick();
        check_vec(tag, {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic check_xfer(input string tag, input int idx, input logic [11:0] exp);
        logic [11:0] got;
        got = (idx < xfer_q.size()) ? xfer_q[idx] : 12'hxxx;
        check_vec(tag, {20'b0, got}, {20'b0, exp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, " instr"}, {20'b0, instr}, 32'hE00);
        check_vec({tag, " valid"}, {31'b0, instr_valid}, 32'd0);
        check_vec({tag, " busy"},  {31'b0, busy}, 32'd0);
        check_vec({tag, " done"},  {31'b0, done}, 32'd0);
        check_vec({tag, " pc"},    {29'b0, pc}, 32'd0);
        check_vec({tag, " add"},   {29'b0, IM_add}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; start_l = 1'b0; stop_l = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 12'hFFF;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("rst");

        // Two words then HALT; also checks the 3-edge start latency.
        mem[0] = 12'h601; mem[1] = 12'h6C2; mem[2] = 12'hFFF;
        xfer_q.delete();
        pulse_start();
        check_vec("t1 busy after start", {31'b0, busy}, 32'd1);
        tick();
        check_vec("t1 valid edge2", {31'b0, instr_valid}, 32'd0);
        tick();
        check_vec("t1 valid edge3", {31'b0, instr_valid}, 32'd1);
        check_vec("t1 first instr", {20'b0, instr}, 32'h601);
        wait_done("t1 done", 100);
        check_vec("t1 nxfer", xfer_q.size(), 32'd4);
        check_xfer("t1 x0", 0, 12'h601);
        check_xfer("t1 x1", 1, 12'hE00);
        check_xfer("t1 x2", 2, 12'h6C2);
        check_xfer("t1 x3", 3, 12'hE00);
        check_vec("t1 busy", {31'b0, busy}, 32'd0);
        check_vec("t1 pc", {29'b0, pc}, 32'd2);
        check_vec("t1 valid", {31'b0, instr_valid}, 32'd0);

        // Repeated word still gets separated; restart from DONE.
        mem[0] = 12'h652; mem[1] = 12'h652; mem[2] = 12'hFFF;
        xfer_q.delete();
        pulse_start();
        check_vec("t2 done cleared", {31'b0, done}, 32'd0);
        check_vec("t2 pc rewound", {29'b0, pc}, 32'd0);
        wait_done("t2 done", 100);
        check_vec("t2 nxfer", xfer_q.size(), 32'd4);
        check_xfer("t2 x0", 0, 12'h652);
        check_xfer("t2 x1", 1, 12'hE00);
        check_xfer("t2 x2", 2, 12'h652);
        check_xfer("t2 x3", 3, 12'hE00);

        // stop in DONE has no effect.
        stop = 1'b1; tick(); stop = 1'b0;
        check_vec("stop in done", {31'b0, done}, 32'd1);

        // Backpressure: instr held stable with ready low.
        mem[0] = 12'h601; mem[1] = 12'hFFF;
        xfer_q.delete();
        instr_ready = 1'b0;
        pulse_start();
        wait_valid("t3 valid", 10);
        for (int i = 0; i < 10; i++) begin
            check_vec("t3 hold instr", {20'b0, instr}, 32'h601);
            check_vec("t3 hold valid", {31'b0, instr_valid}, 32'd1);
            tick();
        end
        check_vec("t3 no early xfer", xfer_q.size(), 32'd0);
        instr_ready = 1'b1;
        tick();
        check_vec("t3 sep instr", {20'b0, instr}, 32'hE00);
        check_vec("t3 sep valid", {31'b0, instr_valid}, 32'd1);
        check_xfer("t3 x0", 0, 12'h601);
        wait_done("t3 done", 100);

        // LOOP=1 wraps 7 -> 0 and never leaves busy.
        for (int i = 0; i < 8; i++) mem[i] = 12'h100 + 12'(i);
        xfer_l_q.delete();
        start_l = 1'b1; tick(); start_l = 1'b0;
        loop_run = 1'b1;
        for (int i = 0; i < 400 && xfer_l_q.size() < 40; i++) tick();
        loop_run = 1'b0;
        check_vec("t4 nxfer", {31'b0, xfer_l_q.size() >= 40}, 32'd1);
        check_vec("t4 busy low cycles", busy_low_cnt, 32'd0);
        for (int w = 0; w < 20; w++) begin
            logic [11:0] gw, gs;
            gw = (2*w < xfer_l_q.size())   ? xfer_l_q[2*w]   : 12'hxxx;
            gs = (2*w+1 < xfer_l_q.size()) ? xfer_l_q[2*w+1] : 12'hxxx;
            check_vec("t4 word", {20'b0, gw}, {20'b0, 12'h100 + 12'(w % 8)});
            check_vec("t4 sep",  {20'b0, gs}, 32'hE00);
        end
        stop_l = 1'b1; tick(); stop_l = 1'b0;
        check_vec("t4 stopped", {31'b0, busy_l}, 32'd0);

        // stop in PACE at pc=3, then restart from 0.
        for (int i = 0; i < 5; i++) mem[i] = 12'h201 + 12'(i);
        for (int i = 5; i < 8; i++) mem[i] = 12'hFFF;
        pulse_start();
        for (int i = 0; i < 100 && !(pc == 3'd3 && instr_valid && instr == 12'hE00); i++) tick();
        check_vec("t5 reach sep pc3", {31'b0, pc == 3'd3 && instr_valid}, 32'd1);
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        check_vec("t5 busy", {31'b0, busy}, 32'd0);
        check_vec("t5 valid", {31'b0, instr_valid}, 32'd0);
        check_vec("t5 instr", {20'b0, instr}, 32'hE00);
        check_vec("t5 pc holds", {29'b0, pc}, 32'd3);
        tick(); tick();
        check_vec("t5 stays idle", {31'b0, busy}, 32'd0);
        pulse_start();
        check_vec("t5 restart add", {29'b0, IM_add}, 32'd0);
        check_vec("t5 restart busy", {31'b0, busy}, 32'd1);
        wait_done("t5 done", 200);
        check_vec("t5 pc at halt", {29'b0, pc}, 32'd5);

        // Reset mid-ISSUE, then start+stop together in IDLE.
        instr_ready = 1'b0;
        pulse_start();
        wait_valid("t6 valid", 10);
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_outputs("t6 rst");
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check_vec("t6 ss busy", {31'b0, busy}, 32'd0);
        tick(); tick();
        check_reset_outputs("t6 ss");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
